// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: scan codes, prefix and control bytes,
// odd-parity helper and the prefix FSM state type.
package ps2_pkg;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;

  // Keyboard status/ack bytes that carry no key information
  localparam int          CTRL_COUNT = 6;
  localparam logic [47:0] CTRL_LIST  = {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } key_state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic is_control(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CTRL_COUNT; i++) begin
      if (CTRL_LIST[i*8 +: 8] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: pin synchronizers, clock glitch filter, 11-bit deserializer
// with start/parity/stop checks and an inter-bit timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]            clk_sync_reg;
  logic [1:0]            data_sync_reg;
  logic [FILTER_LEN-1:0] filter_reg;
  logic                  filt_clk_reg;
  logic [10:0]           frame_reg;
  logic [3:0]            bit_cnt_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic [7:0]            byte_reg;
  logic                  byte_valid_reg;
  logic                  frame_err_reg;

  logic        fall_edge;
  logic [10:0] frame_next;
  logic        frame_ok;

  // The edge is taken in the same cycle the filtered clock commits to 0
  assign fall_edge  = filt_clk_reg && (filter_reg == '0);
  assign frame_next = {data_sync_reg[1], frame_reg[10:1]};
  assign frame_ok   = !frame_next[0] && frame_next[10] &&
                      (frame_next[9] == odd_parity(frame_next[8:1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg   <= 2'b11;
      data_sync_reg  <= 2'b11;
      filter_reg     <= '1;
      filt_clk_reg   <= 1'b1;
      frame_reg      <= '0;
      bit_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      clk_sync_reg   <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg  <= {data_sync_reg[0], ps2_data};
      filter_reg     <= {filter_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (filter_reg == '1)      filt_clk_reg <= 1'b1;
      else if (filter_reg == '0) filt_clk_reg <= 1'b0;

      if (fall_edge) begin
        frame_reg   <= frame_next;
        tmo_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          if (frame_ok) begin
            byte_reg       <= frame_next[8:1];
            byte_valid_reg <= 1'b1;
          end else begin
            frame_err_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // Stalled partial frame is dropped silently
        if (tmo_cnt_reg == TW'(TIMEOUT)) begin
          bit_cnt_reg <= '0;
          tmo_cnt_reg <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
      end
    end
  end

  assign rx_byte    = byte_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: folds E0/F0 prefixes into a held-key level output
// for the maze movement logic.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  key_state_t state_reg, state_next;
  logic [7:0] key_code_reg, key_code_next;
  logic       key_ext_reg, key_ext_next;
  logic       key_valid_reg, key_valid_next;
  logic       is_pfx, do_make, do_break, ev_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      key_code_reg  <= '0;
      key_ext_reg   <= 1'b0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_code_reg  <= key_code_next;
      key_ext_reg   <= key_ext_next;
      key_valid_reg <= key_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    key_code_next  = key_code_reg;
    key_ext_next   = key_ext_reg;
    key_valid_next = 1'b0;
    do_make        = 1'b0;
    do_break       = 1'b0;
    ev_ext         = 1'b0;
    is_pfx         = (rx_byte == PFX_EXT) || (rx_byte == PFX_BRK);
    if (byte_valid) begin
      if (is_control(rx_byte)) begin
        state_next = IDLE;
      end else begin
        // Repeated or out-of-order prefixes accumulate instead of decoding
        case (state_reg)
          IDLE: begin
            if (rx_byte == PFX_EXT)      state_next = EXT;
            else if (rx_byte == PFX_BRK) state_next = BRK;
            else                         do_make    = 1'b1;
          end
          EXT: begin
            ev_ext = 1'b1;
            if (rx_byte == PFX_BRK)      state_next = EXT_BRK;
            else if (!is_pfx)            do_make    = 1'b1;
          end
          BRK: begin
            if (rx_byte == PFX_EXT)      state_next = EXT_BRK;
            else if (!is_pfx)            do_break   = 1'b1;
          end
          default: begin
            ev_ext = 1'b1;
            if (!is_pfx) do_break = 1'b1;
          end
        endcase
        if (!is_pfx) state_next = IDLE;
      end
    end
    if (do_make) begin
      key_code_next  = rx_byte;
      key_ext_next   = ev_ext;
      key_valid_next = 1'b1;
    end
    // Only releasing the currently held key clears the output
    if (do_break && rx_byte == key_code_reg && ev_ext == key_ext_reg) begin
      key_code_next = '0;
      key_ext_next  = 1'b0;
    end
  end

  assign key_code  = key_code_reg;
  assign key_ext   = key_ext_reg;
  assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of frames with expected held key
// and pulse counts, plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int TMO  = 300;
  localparam int HALF = 30;
  localparam int GAP  = 40;
  localparam int NVEC = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int viol   = 0;
  logic kv_prev = 1'b0;
  logic fe_prev = 1'b0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    kv_cnt  <= kv_cnt + int'(key_valid);
    fe_cnt  <= fe_cnt + int'(frame_err);
    kv_prev <= key_valid;
    fe_prev <= frame_err;
    if ((key_valid && frame_err) || (key_valid && kv_prev) || (frame_err && fe_prev))
      viol <= viol + 1;
  end

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    logic [7:0] exp_code;
    bit         exp_ext;
    int         exp_kv;
    int         exp_fe;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] f;
    f = {1'b1, odd_parity(d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        repeat (12) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(posedge clk);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  // Sends one full frame and checks held key and pulse counts afterwards
  task automatic frame_check(input string name, input logic [7:0] d, input bit glitch,
                             input logic [7:0] exp_code, input bit exp_ext,
                             input int exp_kv, input int exp_fe);
    int kv0, fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(d, 1'b0, 11, glitch);
    $display("%s: data=%h code=%h ext=%b kv=%0d fe=%0d", name, d, key_code, key_ext,
             kv_cnt - kv0, fe_cnt - fe0);
    check({name, " code"}, key_code, exp_code);
    check({name, " ext"}, key_ext, exp_ext);
    check({name, " key_valid"}, kv_cnt - kv0, exp_kv);
    check({name, " frame_err"}, fe_cnt - fe0, exp_fe);
  endtask

  initial begin
    int kv0, fe0;
    vecs[0]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[1]  = '{SC_LEFT, 1'b0, SC_LEFT, 1'b1, 1, 0};
    vecs[2]  = '{8'hE0, 1'b0, SC_LEFT, 1'b1, 0, 0};
    vecs[3]  = '{8'hF0, 1'b0, SC_LEFT, 1'b1, 0, 0};
    vecs[4]  = '{SC_LEFT, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[5]  = '{8'h1D, 1'b1, 8'h00, 1'b0, 0, 1};
    vecs[6]  = '{8'h1D, 1'b0, 8'h1D, 1'b0, 1, 0};
    vecs[7]  = '{SC_UP, 1'b0, SC_UP, 1'b0, 1, 0};
    vecs[8]  = '{SC_UP, 1'b0, SC_UP, 1'b0, 1, 0};
    vecs[9]  = '{SC_RIGHT, 1'b0, SC_RIGHT, 1'b0, 1, 0};
    vecs[10] = '{8'hF0, 1'b0, SC_RIGHT, 1'b0, 0, 0};
    vecs[11] = '{SC_UP, 1'b0, SC_RIGHT, 1'b0, 0, 0};
    vecs[12] = '{8'hF0, 1'b0, SC_RIGHT, 1'b0, 0, 0};
    vecs[13] = '{SC_RIGHT, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[14] = '{8'hE0, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[15] = '{8'hAA, 1'b0, 8'h00, 1'b0, 0, 0};
    vecs[16] = '{SC_LEFT, 1'b0, SC_LEFT, 1'b0, 1, 0};

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset code", key_code, 8'h00);
    check("reset ext", key_ext, 1'b0);
    check("reset key_valid", key_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int v = 0; v < NVEC; v++) begin
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].bad_par, 11, 1'b0);
      $display("vec %0d: data=%h badpar=%0d code=%h ext=%b kv=%0d fe=%0d", v, vecs[v].data,
               vecs[v].bad_par, key_code, key_ext, kv_cnt - kv0, fe_cnt - fe0);
      check($sformatf("vec%0d code", v), key_code, vecs[v].exp_code);
      check($sformatf("vec%0d ext", v), key_ext, vecs[v].exp_ext);
      check($sformatf("vec%0d key_valid", v), kv_cnt - kv0, vecs[v].exp_kv);
      check($sformatf("vec%0d frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
    end

    // Partial frame abandoned long enough to time out, then a clean frame
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 4, 1'b0);
    repeat (TMO + 10) @(posedge clk);
    check("timeout partial frame_err", fe_cnt - fe0, 0);
    check("timeout partial key_valid", kv_cnt - kv0, 0);
    frame_check("timeout", SC_DOWN, 1'b0, SC_DOWN, 1'b0, 1, 0);

    // Short low glitch on ps2_clk mid-frame must not add a bit
    frame_check("glitch", SC_LEFT, 1'b1, SC_LEFT, 1'b0, 1, 0);

    // Reset after an E0 prefix and during a partial frame
    frame_check("pre-reset E0", 8'hE0, 1'b0, SC_LEFT, 1'b0, 0, 0);
    send_frame(SC_LEFT, 1'b0, 5, 1'b0);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("in reset: code=%h ext=%b", key_code, key_ext);
    check("mid reset code", key_code, 8'h00);
    check("mid reset ext", key_ext, 1'b0);
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    frame_check("post-reset", SC_LEFT, 1'b0, SC_LEFT, 1'b0, 1, 0);

    check("pulse overlap/back-to-back", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the serial PS/2 keyboard stream and turns it into the held-key code consumed by the maze movement logic. Filters the keyboard clock, deserializes 11-bit frames, and checks parity and framing. Folds E0 (extended) and F0 (break) prefixes into a level output: `key_code` holds the scan code of the key currently held down and returns to 8'h00 when that key is released. Sits between the keyboard pins and the character-move block.

## Interface
- `FILTER_LEN`, 8: system-clock samples of `ps2_clk` that must agree before the filtered clock changes level.
- `TIMEOUT`, 50_000: system-clock cycles without a filtered falling edge before a partial frame is discarded.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  raw keyboard clock; asynchronous; double-registered internally.
- `ps2_data`  in  1  raw keyboard data; asynchronous; double-registered internally.
- `key_code`  out  8  Set-2 scan code of the held key; 8'h00 when no key is held.
- `key_ext`  out  1  1 when `key_code` arrived with an E0 prefix.
- `key_valid`  out  1  one-cycle pulse on every accepted make code, including typematic repeats.
- `frame_err`  out  1  one-cycle pulse when a frame fails its start, parity or stop check.

## Operation
- Filter: shift register of `FILTER_LEN` synchronized `ps2_clk` samples. Filtered clock goes 0 when all bits are 0 and goes 1 when all bits are 1; otherwise it holds. A falling edge is a 1→0 transition of the filtered clock.
- Frame: on each falling edge, sample `ps2_data` into an 11-bit shift register, LSB first. The frame is start(0), D0–D7, odd parity, stop(1). A 4-bit counter (0–10) counts the bits.
- Frame check on the 11th bit:
  - Accept when start=0, stop=1 and XOR of data plus parity = 1. Accepting pulses an internal `byte_valid`.
  - Otherwise pulse `frame_err` and discard the byte.
  - In both cases the counter returns to 0.
- Timeout: a cycle counter runs while the bit counter is non-zero and is cleared on each falling edge. When it reaches `TIMEOUT`, the bit counter goes to 0. This is silent: no `frame_err`.
- Prefix FSM states are IDLE, EXT, BRK and EXT_BRK. In every state, a byte that is not a prefix or a control byte returns the FSM to IDLE.
  - IDLE: E0→EXT, F0→BRK, other→make(ext=0).
  - EXT: F0→EXT_BRK, other→make(ext=1).
  - BRK: other→break(ext=0).
  - EXT_BRK: other→break(ext=1).
- Make: `key_code`←byte, `key_ext`←ext, pulse `key_valid`.
- Break: if byte==`key_code` and ext==`key_ext`, then `key_code`←00 and `key_ext`←0. Otherwise outputs are unchanged; releasing a non-held key has no effect.
- Control bytes 00, AA, E1, FA, FE and FF: the FSM goes to IDLE and outputs are unchanged.
- Simultaneous keys: the last make wins. Breaking an older key does not clear a newer one.

## Timing
- Reset values:
  - `key_code`=00, `key_ext`=0, `key_valid`=0, `frame_err`=0.
  - FSM=IDLE; bit and timeout counters=0.
  - Filter register all 1s, so the filtered clock is 1.
- Pin-to-filtered-clock delay: 2 synchronizer cycles plus `FILTER_LEN` cycles.
- Cycle N = the cycle in which the stop-bit falling edge is detected.
  - N+1: `byte_valid` or `frame_err` pulses.
  - N+2: `key_code`, `key_ext` and `key_valid` update.
- Reset asserted mid-frame discards the partial frame and any pending prefix. The first valid frame after reset deasserts decodes normally.
- `key_valid` and `frame_err` are never high in the same cycle and are never high for two consecutive cycles.

## Structure
- Shared package `ps2_pkg` holds:
  - constants `SC_LEFT`=8'h6B, `SC_RIGHT`=8'h74, `SC_UP`=8'h75, `SC_DOWN`=8'h72, `PFX_EXT`=8'hE0, `PFX_BRK`=8'hF0, plus the control-byte list;
  - an odd-parity function;
  - the FSM state typedef.
- Sub-module `ps2_frame_rx` contains synchronizer, filter, deserializer, frame checks and timeout, and outputs `byte`, `byte_valid` and `frame_err`. `ps2_key_decoder` instantiates it and holds the prefix FSM and the output registers.

## Test plan
- Left-arrow press and release. Send frames E0, 6B, then E0, F0, 6B at a 12.5 kHz PS/2 clock.
  - After the second frame: `key_code`=6B, `key_ext`=1, one `key_valid` pulse.
  - After the break: `key_code`=00, `key_ext`=0.
- Parity error: send 1D with even parity → one `frame_err` pulse; `key_code` stays 00; the next good 1D gives `key_code`=1D.
- Typematic and overlap: send 75, 75, 74, F0 75.
  - Two `key_valid` pulses for 75, then `key_code`=74.
  - The break of 75 leaves 74 unchanged.
- Timeout: send 4 bits, idle for `TIMEOUT`+10 cycles, then send a full frame 72 → `key_code`=72, no `frame_err`.
- Glitch rejection: a `ps2_clk` low pulse of `FILTER_LEN`-2 cycles mid-frame causes no extra bit sample; a following frame 6B decodes correctly.
- Reset between E0 and 6B → after reset, 6B decodes with `key_ext`=0; outputs are 00/0 during reset.
